// File: rtl/dadda_pkg.sv
// dadda_pkg: shared definitions for the Dadda multiplier datapath.
//   cpa_state_t  : state encoding of the final carry-propagate adder FSM
//   DADDA_WIDTH  : default product width, shared with the reduction tree
//   DADDA_CHUNK  : default bits resolved per cycle by dadda_cpa
package dadda_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } cpa_state_t;

  localparam int DADDA_WIDTH = 16;
  localparam int DADDA_CHUNK = 4;

endpackage

// File: rtl/dadda_cpa_slice.sv
// full_adder : one-bit full adder cell, also used by the reduction tree.
//   a, b, cin -> sum, cout
// cpa_slice  : CHUNK-bit ripple-carry adder built from full_adder cells.
//   a, b  [CHUNK-1:0] operand chunks
//   cin               carry into bit 0
//   sum   [CHUNK-1:0] chunk sum
//   cout              carry out of bit CHUNK-1
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

module cpa_slice #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  logic [CHUNK:0] carry_s;

  assign carry_s[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry_s[i]),
      .sum  (sum[i]),
      .cout (carry_s[i+1])
    );
  end

  assign cout = carry_s[CHUNK];

endmodule

// File: rtl/dadda_cpa.sv
// dadda_cpa: final carry-propagate adder after the Dadda reduction tree.
// Resolves the redundant (sum row, carry row) pair into a binary product,
// CHUNK bits per cycle, using one shared cpa_slice.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : input handshake (in_ready high only in IDLE)
//   in_sum, in_carry    : rows to add, result = in_sum + in_carry mod 2^WIDTH
//   out_valid/out_ready : output handshake (out_valid high in DONE)
//   out_prod, out_cout  : resolved product and carry out of bit WIDTH-1
// Optional build macro DADDA_CPA_SKIP_EN: stop early once the remaining
// upper operand bits are zero and no carry is pending.
module dadda_cpa
  import dadda_pkg::*;
#(
  parameter int WIDTH = DADDA_WIDTH,
  parameter int CHUNK = DADDA_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic [WIDTH-1:0] in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_prod,
  output logic             out_cout
);

  localparam int NCH  = WIDTH / CHUNK;
  localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;

  if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_cfg
    $error("dadda_cpa: CHUNK must be >= 1 and divide WIDTH");
  end

  cpa_state_t       state_r;
  cpa_state_t       state_nx_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] result_r;
  logic             carry_r;
  logic [IDXW-1:0]  idx_r;
  logic             out_cout_r;
  logic             out_valid_r;
  logic [CHUNK-1:0] a_chunk_s;
  logic [CHUNK-1:0] b_chunk_s;
  logic [CHUNK-1:0] slice_sum_s;
  logic             slice_cout_s;
  logic             last_s;
  logic             skip_s;
  logic             finish_s;

  // Select the operand chunk addressed by the index counter.
  always_comb begin
    a_chunk_s = {CHUNK{1'b0}};
    b_chunk_s = {CHUNK{1'b0}};
    for (int i = 0; i < NCH; i++) begin
      a_chunk_s = (idx_r == IDXW'(i)) ? a_r[i*CHUNK +: CHUNK] : a_chunk_s;
      b_chunk_s = (idx_r == IDXW'(i)) ? b_r[i*CHUNK +: CHUNK] : b_chunk_s;
    end
  end

  cpa_slice #(
    .CHUNK (CHUNK)
  ) u_slice (
    .a    (a_chunk_s),
    .b    (b_chunk_s),
    .cin  (carry_r),
    .sum  (slice_sum_s),
    .cout (slice_cout_s)
  );

  assign last_s = (idx_r == IDXW'(NCH - 1));

`ifdef DADDA_CPA_SKIP_EN
  // Early exit: nothing left above the current chunk and no carry to ripple.
  always_comb begin
    skip_s = 1'b0;
    for (int i = 0; i < NCH - 1; i++) begin
      skip_s = (idx_r == IDXW'(i))
             ? (~slice_cout_s & (((a_r | b_r) >> ((i + 1) * CHUNK)) == {WIDTH{1'b0}}))
             : skip_s;
    end
  end
`else
  assign skip_s = 1'b0;
`endif

  assign finish_s = last_s | skip_s;

  // Next-state logic of the IDLE -> ADD -> DONE sequence.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_nx_s = ADD;
        end else begin
          state_nx_s = IDLE;
        end
      end
      ADD: begin
        if (finish_s) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = ADD;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = DONE;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // State register; out_valid is registered alongside it from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      out_valid_r <= (state_nx_s == DONE);
    end
  end

  // Operand capture, per-chunk result write-back, carry and index update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r        <= {WIDTH{1'b0}};
      b_r        <= {WIDTH{1'b0}};
      result_r   <= {WIDTH{1'b0}};
      carry_r    <= 1'b0;
      idx_r      <= {IDXW{1'b0}};
      out_cout_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r        <= in_sum;
            b_r        <= in_carry;
            // Cleared so that chunks skipped by early exit read as zero.
            result_r   <= {WIDTH{1'b0}};
            carry_r    <= 1'b0;
            idx_r      <= {IDXW{1'b0}};
            out_cout_r <= 1'b0;
          end
        end
        ADD: begin
          for (int i = 0; i < NCH; i++) begin
            if (idx_r == IDXW'(i)) begin
              result_r[i*CHUNK +: CHUNK] <= slice_sum_s;
            end
          end
          carry_r <= slice_cout_s;
          idx_r   <= idx_r + IDXW'(1);
          // On an early exit slice_cout_s is 0, which is the correct cout.
          if (finish_s) begin
            out_cout_r <= slice_cout_s;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = (state_r == IDLE);
  assign out_valid = out_valid_r;
  assign out_prod  = result_r;
  assign out_cout  = out_cout_r;

endmodule

// File: doc/dadda_cpa.md
Name: dadda_cpa

Overview:
Final carry-propagate adder stage, directly downstream of the Dadda reduction tree built from half_adder/full_adder/compress42 cells. Takes the two-row redundant output of the tree (sum row, carry row) and resolves it into the binary product. Works sequentially, CHUNK bits per cycle, to keep the carry chain short. Valid/ready handshake on both sides.

Parameters:
WIDTH, 16, product width in bits; width of both operand rows and the result.
CHUNK, 4, bits resolved per ADD cycle; WIDTH % CHUNK == 0 and CHUNK >= 1 are required (elaboration-time check).

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  in_sum/in_carry valid
in_ready  output  1  stage can accept; equals (state == IDLE), combinational from state only
in_sum  input  WIDTH  sum row from the reduction tree
in_carry  input  WIDTH  carry row, already weight-aligned by the tree; result = in_sum + in_carry mod 2^WIDTH
out_valid  output  1  out_prod/out_cout valid
out_ready  input  1  consumer accepts the result
out_prod  output  WIDTH  resolved product
out_cout  output  1  carry out of bit WIDTH-1

Behaviour:
- NCH = WIDTH/CHUNK. Index counter width is clog2(NCH), minimum 1 bit.
- Reset (async assert, any state, including mid-ADD): state=IDLE, out_valid=0, out_prod=0, out_cout=0, internal carry=0, index=0, operand registers=0. An operation in flight is discarded.
- FSM:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch in_sum->A and in_carry->B, clear the result register and carry, set index=0, go to ADD.
  - ADD: each cycle, result[idx*CHUNK +: CHUNK] <= A_chunk + B_chunk + carry. Carry <= chunk carry-out. idx++. On the cycle with idx == NCH-1, write out_cout <= chunk carry-out and go to DONE.
  - DONE: out_valid=1, and out_prod/out_cout are held stable. On out_ready, go to IDLE (out_valid drops the next cycle).
- Latency: out_valid rises exactly NCH cycles after the accepting edge. Throughput is one operation per NCH+2 cycles minimum. DONE->IDLE and the next accept never occur in the same cycle.
- in_valid and in_ready have no effect outside IDLE. Input changes after accept are ignored.
- out_ready while not in DONE has no effect. Under backpressure, DONE holds indefinitely.
- out_prod is driven from the result register at all times. It is only meaningful while out_valid=1.
- CHUNK == WIDTH: a single ADD cycle, latency 1.

Optional Feature:
DADDA_CPA_SKIP_EN
- Defined: early termination. In ADD, after resolving chunk idx, if its carry-out is 0 and A and B are both zero above bit (idx+1)*CHUNK-1, go to DONE immediately. Upper result bits stay 0 (cleared at accept) and out_cout=0. Latency becomes 1..NCH cycles.
- Undefined: latency is always exactly NCH. No zero-detect logic is synthesized.

Decomposition:
- Package dadda_pkg: typedef cpa_state_t {IDLE, ADD, DONE}, plus the default WIDTH and CHUNK localparams shared with the reduction tree.
- Sub-module cpa_slice: CHUNK-bit ripple adder (a, b, cin -> sum, cout) built from the existing full_adder cell via a generate loop. It is instantiated once and shared across cycles.
- The FSM, counter, and registers live in dadda_cpa.

Test Plan:
- WIDTH=16, CHUNK=4: in_sum=0x00FF, in_carry=0x0001 -> out_prod=0x0100, out_cout=0, out_valid exactly 4 cycles after accept.
- in_sum=0xFFFF, in_carry=0x0001 -> out_prod=0x0000, out_cout=1 (full carry ripple across all chunks).
- Backpressure: result 0x1234+0x4321 -> out_prod=0x5555 held with out_valid=1 while out_ready=0 for 5 cycles; drops the cycle after out_ready=1. in_ready stays 0 throughout.
- Reset mid-ADD (assert rst 2 cycles after accept) -> immediately out_valid=0, out_prod=0, in_ready=1 after release. A new op 0x0002+0x0003 then gives 0x0005.
- Back-to-back: in_valid held high with 3 operand pairs and out_ready=1 -> 3 correct results, each spaced NCH+2=6 cycles apart, with no operand loss.
- DADDA_CPA_SKIP_EN defined: 0x0003+0x0004 -> out_prod=0x0007 after 1 ADD cycle. 0x00F0+0x0010 -> 0x0100 after 3 cycles. Undefined: both take 4 cycles.
